alu_ctrl: RTL
=============

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default `WORD_SIZE, datapath width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 8, number of general registers (power of 2).
REQ-003 SHALL have clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have instr_valid / instr_ready  input / output  1 / 1  instruction handshake.
REQ-006 SHALL have instr_op  input  opcode_t  operation (ADD, ADC, SUB, AND, OR, XOR, CMP, INC, DEC, SHR, SHL).
REQ-007 SHALL have instr_rx, instr_ry  input  log2(NUM_REGS) each  destination/first source, second source.
REQ-008 SHALL have alu_opcode, alu_a, alu_b, alu_carry_in  output  opcode_t, WORD_SIZE, WORD_SIZE, 1  drive to ALU.
REQ-009 SHALL have alu_out, alu_flag_c, alu_flag_z, alu_flag_n  input  WORD_SIZE, 1, 1, 1  ALU results (combinational).
REQ-010 SHALL have resp_valid / resp_ready  output / input  1 / 1  completion handshake.
REQ-011 SHALL have resp_data  output  WORD_SIZE  ALU result of completed instruction.
REQ-012 SHALL have flag_c, flag_z, flag_n  output  1 each  architectural flags register.
REQ-013 SHALL have host_wr_en, host_wr_addr, host_wr_data  input  1, log2(NUM_REGS), WORD_SIZE  register preload port.
REQ-014 SHALL have dbg_addr / dbg_data  input / output  log2(NUM_REGS) / WORD_SIZE  combinational register read.

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> WB -> RESP -> IDLE.
REQ-016 instr_ready SHALL be 1 only in IDLE with host_wr_en=0; accept = instr_valid & instr_ready; instruction fields latched on accept.
REQ-017 EXEC (cycle after accept): drive alu_opcode=latched op, alu_a=R[rx], alu_b=R[ry], alu_carry_in=flag_c; outputs held stable through WB.
REQ-018 WB: capture alu_out into resp_data; write R[rx] for all ops except CMP.
REQ-019 WB flag update: ADD/ADC/SUB load C,Z,N from ALU; AND/OR/XOR/CMP load Z,N, keep C; INC/DEC/SHR/SHL leave flags unchanged.
REQ-020 resp_valid SHALL assert in RESP (2 cycles after accept edge) and hold, with resp_data stable, until resp_ready=1; then IDLE next cycle.
REQ-021 Minimum issue interval SHALL be 4 cycles; no instruction overlap.
REQ-022 rx==ry SHALL give alu_a==alu_b==R[rx]; write-back to same register permitted.
REQ-023 host_wr_en SHALL write R[host_wr_addr] only in IDLE; in other states ignored; in IDLE it blocks accept that cycle (host priority).
REQ-024 Outside EXEC/WB alu_opcode SHALL be ADD and alu_a, alu_b, alu_carry_in 0.
REQ-025 dbg_data SHALL reflect register contents after the most recent edge.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, all registers 0, flags 0, resp_valid 0, resp_data 0, ALU drive per REQ-024.
REQ-027 Reset mid-instruction SHALL abort it with no write-back, no flag update, no response.
REQ-028 instr_ready SHALL be 0 while rst_n=0 and 1 in first cycle after deassertion (host_wr_en=0).

Configuration
REQ-029 Macro ALU_CTRL_IMM_EN defined: add inputs instr_imm_sel (1) and instr_imm (WORD_SIZE); if instr_imm_sel=1 at accept, alu_b=latched instr_imm instead of R[ry].
REQ-030 ALU_CTRL_IMM_EN undefined: those ports absent; alu_b always R[ry].

Verification (WORD_SIZE=8)
REQ-031 Preload R1=0xF0,R2=0x20; ADD rx=1,ry=2 -> resp_valid 2 cycles after accept, resp_data=0x10, R1=0x10, C=1,Z=0,N=0.
REQ-032 C=1, R3=0x05,R4=0x0A; ADC rx=3,ry=4 -> R3=0x10, alu_carry_in=1 in EXEC; then INC R3 -> R3=0x11, flags unchanged.
REQ-033 R5=R6=0x80; CMP rx=5,ry=6 -> R5 stays 0x80, C unchanged, Z/N from ALU; SUB same -> R5=0x00, Z=1.
REQ-034 resp_ready held 0 for 3 cycles -> resp_valid and resp_data stable, instr_ready 0; next instr accepted 1 cycle after resp handshake.
REQ-035 host_wr_en and instr_valid both high in IDLE -> register written, instruction not accepted until next cycle; rst_n pulsed in WB -> R[rx] and flags remain 0, no response.
REQ-036 With ALU_CTRL_IMM_EN: R1=0x01, SHL imm 3 -> R1=0x08; without: build has no imm ports.

Source files
------------

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_pkg / alu_ctrl_if
//   Opcode type shared by the controller, its ALU and the instruction source,
//   and the instruction/response handshake bundle between a host and alu_ctrl.
//   master : instruction source (drives instr_*, resp_ready)
//   slave  : alu_ctrl (drives instr_ready, resp_valid, resp_data)
//   Build option: ALU_CTRL_IMM_EN adds instr_imm_sel / instr_imm.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package alu_ctrl_pkg;
   typedef enum logic [3:0] {
      ADD = 4'd0,
      ADC = 4'd1,
      SUB = 4'd2,
      AND = 4'd3,
      OR  = 4'd4,
      XOR = 4'd5,
      CMP = 4'd6,
      INC = 4'd7,
      DEC = 4'd8,
      SHR = 4'd9,
      SHL = 4'd10
   } opcode_t;
endpackage

interface alu_ctrl_if #(
   parameter int WORD_SIZE = `WORD_SIZE,
   parameter int REG_AW    = 3
);
   import alu_ctrl_pkg::*;

   logic                 instr_valid;
   logic                 instr_ready;
   opcode_t              instr_op;
   logic [REG_AW-1:0]    instr_rx;
   logic [REG_AW-1:0]    instr_ry;
`ifdef ALU_CTRL_IMM_EN
   logic                 instr_imm_sel;
   logic [WORD_SIZE-1:0] instr_imm;
`endif
   logic                 resp_valid;
   logic                 resp_ready;
   logic [WORD_SIZE-1:0] resp_data;

`ifdef ALU_CTRL_IMM_EN
   modport master (
      output instr_valid, instr_op, instr_rx, instr_ry, instr_imm_sel, instr_imm, resp_ready,
      input  instr_ready, resp_valid, resp_data
   );
   modport slave (
      input  instr_valid, instr_op, instr_rx, instr_ry, instr_imm_sel, instr_imm, resp_ready,
      output instr_ready, resp_valid, resp_data
   );
`else
   modport master (
      output instr_valid, instr_op, instr_rx, instr_ry, resp_ready,
      input  instr_ready, resp_valid, resp_data
   );
   modport slave (
      input  instr_valid, instr_op, instr_rx, instr_ry, resp_ready,
      output instr_ready, resp_valid, resp_data
   );
`endif
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl
//   Sequences one instruction at a time through an external combinational ALU:
//   reads operands from a small register file, writes the result back, updates
//   the architectural flags and returns the result over a response handshake.
// Ports
//   clk, rst_n                     clock, async active-low reset
//   bus (alu_ctrl_if.slave)        instruction / response handshake
//   alu_opcode/a/b/carry_in        drive to ALU (idle value ADD, 0, 0, 0)
//   alu_out, alu_flag_c/z/n        ALU results
//   flag_c, flag_z, flag_n         architectural flags
//   host_wr_en/addr/data           register preload (IDLE only, beats instructions)
//   dbg_addr / dbg_data            combinational register read
// Build option: ALU_CTRL_IMM_EN selects a latched immediate as operand b.
//
// state | meaning
// IDLE  | waiting for instruction; host preload writes allowed
// EXEC  | operands driven to ALU
// WB    | operands held; result, register and flags captured at end of cycle
// RESP  | resp_valid held until resp_ready
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module alu_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int WORD_SIZE = `WORD_SIZE,
   parameter int NUM_REGS  = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   alu_ctrl_if.slave                   bus,
   output opcode_t                     alu_opcode,
   output logic [WORD_SIZE-1:0]        alu_a,
   output logic [WORD_SIZE-1:0]        alu_b,
   output logic                        alu_carry_in,
   input  logic [WORD_SIZE-1:0]        alu_out,
   input  logic                        alu_flag_c,
   input  logic                        alu_flag_z,
   input  logic                        alu_flag_n,
   output logic                        flag_c,
   output logic                        flag_z,
   output logic                        flag_n,
   input  logic                        host_wr_en,
   input  logic [$clog2(NUM_REGS)-1:0] host_wr_addr,
   input  logic [WORD_SIZE-1:0]        host_wr_data,
   input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
   output logic [WORD_SIZE-1:0]        dbg_data
);
   localparam int REG_AW = $clog2(NUM_REGS);

   typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;

   state_t               state, state_nx;
   opcode_t              op_q;
   logic [REG_AW-1:0]    rx_q, ry_q;
   logic [WORD_SIZE-1:0] resp_data_q;
   logic [WORD_SIZE-1:0] regs [NUM_REGS];
   logic [WORD_SIZE-1:0] operand_b;
   logic                 accept;
`ifdef ALU_CTRL_IMM_EN
   logic                 imm_sel_q;
   logic [WORD_SIZE-1:0] imm_q;
`endif

   // rst_n term keeps instr_ready low while reset is held, even though the
   // state register already reads IDLE.
   assign bus.instr_ready = rst_n && (state == IDLE) && !host_wr_en;
   assign accept          = bus.instr_valid && bus.instr_ready;
   assign bus.resp_valid  = (state == RESP);
   assign bus.resp_data   = resp_data_q;
   assign dbg_data        = regs[dbg_addr];

`ifdef ALU_CTRL_IMM_EN
   assign operand_b = imm_sel_q ? imm_q : regs[ry_q];
`else
   assign operand_b = regs[ry_q];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_q        <= ADD;
         rx_q        <= '0;
         ry_q        <= '0;
         resp_data_q <= '0;
         flag_c      <= 1'b0;
         flag_z      <= 1'b0;
         flag_n      <= 1'b0;
`ifdef ALU_CTRL_IMM_EN
         imm_sel_q   <= 1'b0;
         imm_q       <= '0;
`endif
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_q <= bus.instr_op;
            rx_q <= bus.instr_rx;
            ry_q <= bus.instr_ry;
`ifdef ALU_CTRL_IMM_EN
            imm_sel_q <= bus.instr_imm_sel;
            imm_q     <= bus.instr_imm;
`endif
         end
         if ((state == IDLE) && host_wr_en) regs[host_wr_addr] <= host_wr_data;
         if (state == WB) begin
            resp_data_q <= alu_out;
            if (op_q != CMP) regs[rx_q] <= alu_out;
            case (op_q)
               ADD, ADC, SUB: begin
                  flag_c <= alu_flag_c;
                  flag_z <= alu_flag_z;
                  flag_n <= alu_flag_n;
               end
               AND, OR, XOR, CMP: begin
                  flag_z <= alu_flag_z;
                  flag_n <= alu_flag_n;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_nx     = state;
      alu_opcode   = ADD;
      alu_a        = '0;
      alu_b        = '0;
      alu_carry_in = 1'b0;
      if ((state == EXEC) || (state == WB)) begin
         alu_opcode   = op_q;
         alu_a        = regs[rx_q];
         alu_b        = operand_b;
         alu_carry_in = flag_c;
      end
      case (state)
         IDLE:    if (accept) state_nx = EXEC;
         EXEC:    state_nx = WB;
         WB:      state_nx = RESP;
         RESP:    if (bus.resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
endmodule
